// File: rtl/mdpt_swept.sv
// mdpt_swept - memory dependence prediction table with sweep-based clear.
//
// One MDP_W-bit prediction per fetch lane per set. The set is selected by
// hashing the fetch index with the low bits of the current ASID. Reads
// are registered, so a request in cycle N is answered in cycle N+1.
// Single-lane training updates arrive from the LSQ/retire path.
//
// The array has no reset, so it can map onto SRAM. After reset or a
// flush, a sweep clears one set per cycle. While the sweep runs, updates
// are dropped and reads return zero.
//
// Ports
//   CLK                    clock
//   nRST                   asynchronous active-low reset
//   arch_asid              current address-space id, sampled with each request/update
//   read_req_valid         read request this cycle
//   read_req_fetch_index   fetch set index (before hashing)
//   read_resp_valid        response valid, one cycle after the request
//   read_resp_mdp_by_lane  lane i at [i*MDP_W +: MDP_W]; holds when there is no response
//   update_valid           training write
//   update_pc38            PC of trained instruction: [LANE_W-1:0] lane, [LANE_W +: IDX_W] index
//   update_mdp             new prediction
//   flush_valid            clear the whole table (restarts the sweep)
//   init_done              table cleared and usable
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_SWEEP | zeroing set[sweep_ptr] each cycle; updates dropped, reads return 0
// ST_READY | normal read/update operation

module mdpt_swept #(
  parameter int MDPT_SETS   = 128,
  parameter int FETCH_LANES = 8,
  parameter int MDP_W       = 8,
  parameter int ASID_W      = 16,
  parameter int PC_W        = 38,
  localparam int IDX_W      = $clog2(MDPT_SETS),
  localparam int LANE_W     = $clog2(FETCH_LANES)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [ASID_W-1:0]            arch_asid,
  input  logic                         read_req_valid,
  input  logic [IDX_W-1:0]             read_req_fetch_index,
  output logic                         read_resp_valid,
  output logic [FETCH_LANES*MDP_W-1:0] read_resp_mdp_by_lane,
  input  logic                         update_valid,
  input  logic [PC_W-1:0]              update_pc38,
  input  logic [MDP_W-1:0]             update_mdp,
  input  logic                         flush_valid,
  output logic                         init_done
);

  typedef enum logic {ST_SWEEP, ST_READY} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               sweep_ptr;
  logic [MDP_W-1:0]               mem [MDPT_SETS][FETCH_LANES];

  logic [IDX_W-1:0]               rd_set;
  logic [IDX_W-1:0]               upd_set;
  logic [LANE_W-1:0]              upd_lane;
  logic                           upd_en;
  logic [FETCH_LANES*MDP_W-1:0]   rd_word;

  // Upper ASID and PC bits do not take part in the hash.
  logic unused_bits;
  assign unused_bits = ^{arch_asid, update_pc38};

  assign rd_set   = read_req_fetch_index ^ arch_asid[IDX_W-1:0];
  assign upd_set  = update_pc38[LANE_W +: IDX_W] ^ arch_asid[IDX_W-1:0];
  assign upd_lane = update_pc38[LANE_W-1:0];
  // A flush in the same cycle wins over the update.
  assign upd_en   = update_valid && (state == ST_READY) && !flush_valid;

  // Storage: no reset, cleared only by the sweep.
  always_ff @(posedge CLK) begin
    if (state == ST_SWEEP) begin
      for (int l = 0; l < FETCH_LANES; l++) begin
        mem[sweep_ptr][l] <= '0;
      end
    end else if (upd_en) begin
      mem[upd_set][upd_lane] <= update_mdp;
    end
  end

  // Write-first forwarding: a same-cycle update to the read set shows up
  // in the response.
  always_comb begin
    rd_word = '0;
    for (int l = 0; l < FETCH_LANES; l++) begin
      if (upd_en && (upd_set == rd_set) && (upd_lane == LANE_W'(l))) begin
        rd_word[l*MDP_W +: MDP_W] = update_mdp;
      end else begin
        rd_word[l*MDP_W +: MDP_W] = mem[rd_set][l];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state                 <= ST_SWEEP;
      sweep_ptr             <= '0;
      init_done             <= 1'b0;
      read_resp_valid       <= 1'b0;
      read_resp_mdp_by_lane <= '0;
    end else begin
      read_resp_valid <= read_req_valid;
      if (read_req_valid) begin
        read_resp_mdp_by_lane <= (state == ST_READY) ? rd_word : '0;
      end

      case (state)
        ST_SWEEP: begin
          if (flush_valid) begin
            sweep_ptr <= '0;
          end else if (sweep_ptr == IDX_W'(MDPT_SETS - 1)) begin
            sweep_ptr <= '0;
            state     <= ST_READY;
            init_done <= 1'b1;
          end else begin
            sweep_ptr <= sweep_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (flush_valid) begin
            sweep_ptr <= '0;
            state     <= ST_SWEEP;
            init_done <= 1'b0;
          end
        end
        default: begin
          state <= ST_SWEEP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdpt_swept.sv
// tb_mdpt_swept - scoreboard bench for mdpt_swept.
// The reference model is a plain 2-D array plus a countdown of the cycles
// left until the table is usable. The driver pushes the expected payload
// of every read. A negedge monitor pops the queue and checks each
// response. It also checks init_done, resp_valid, and that the payload
// holds when there is no response.

module tb_mdpt_swept;
  localparam int SETS  = 128;
  localparam int LANES = 8;
  localparam int MW    = 8;
  localparam int AW    = 16;
  localparam int PW    = 38;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          nRST;
  logic [AW-1:0] arch_asid;
  logic          rqv;
  logic [6:0]    rqi;
  logic          rrv;
  logic [63:0]   rrd;
  logic          uv;
  logic [PW-1:0] upc;
  logic [MW-1:0] umdp;
  logic          flush;
  logic          init_done;

  mdpt_swept u_dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .arch_asid             (arch_asid),
    .read_req_valid        (rqv),
    .read_req_fetch_index  (rqi),
    .read_resp_valid       (rrv),
    .read_resp_mdp_by_lane (rrd),
    .update_valid          (uv),
    .update_pc38           (upc),
    .update_mdp            (umdp),
    .flush_valid           (flush),
    .init_done             (init_done)
  );

  // Smaller parameter variant: 32 sets, 4 lanes, 5-bit predictions.
  logic        s_rst;
  logic [15:0] s_asid;
  logic        s_rqv;
  logic [4:0]  s_rqi;
  logic        s_rrv;
  logic [19:0] s_rrd;
  logic        s_uv;
  logic [37:0] s_upc;
  logic [4:0]  s_umdp;
  logic        s_flush;
  logic        s_init;

  mdpt_swept #(.MDPT_SETS(32), .FETCH_LANES(4), .MDP_W(5)) u_small (
    .CLK                   (CLK),
    .nRST                  (s_rst),
    .arch_asid             (s_asid),
    .read_req_valid        (s_rqv),
    .read_req_fetch_index  (s_rqi),
    .read_resp_valid       (s_rrv),
    .read_resp_mdp_by_lane (s_rrd),
    .update_valid          (s_uv),
    .update_pc38           (s_upc),
    .update_mdp            (s_umdp),
    .flush_valid           (s_flush),
    .init_done             (s_init)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] mdl [SETS][LANES];
  int            rem;
  logic [63:0]   q[$];
  logic          exp_rv;
  logic [63:0]   last_pl;
  logic [63:0]   mon_e;
  bit            started = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < SETS; s++)
      for (int l = 0; l < LANES; l++)
        mdl[s][l] = '0;
  endtask

  function automatic logic [63:0] row(input int s);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*MW +: MW] = mdl[s][l];
    return r;
  endfunction

  // Random upper PC bits; they must be ignored by the DUT.
  function automatic logic [PW-1:0] pc(input int idx, input int lane);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[9:0] = {7'(idx), 3'(lane)};
    return r[PW-1:0];
  endfunction

  task automatic idle();
    rqv = 1'b0; uv = 1'b0; flush = 1'b0;
  endtask

  // One clock cycle of stimulus plus the reference-model update.
  task automatic step();
    int rs, us, ul;
    bit rdy;
    logic [63:0] e;
    rdy = (rem == 0);
    rs  = int'(rqi ^ arch_asid[6:0]);
    us  = int'(upc[9:3] ^ arch_asid[6:0]);
    ul  = int'(upc[2:0]);
    if (nRST && rqv) begin
      e = rdy ? row(rs) : 64'd0;
      if (rdy && uv && !flush && us == rs) e[ul*MW +: MW] = umdp;
      q.push_back(e);
    end
    @(posedge CLK);
    if (!nRST) begin
      clear_model();
      rem    = SETS;
      exp_rv = 1'b0;
    end else begin
      exp_rv = rqv;
      if (rdy && uv && !flush) mdl[us][ul] = umdp;
      if (flush) begin
        clear_model();
        rem = SETS;
      end else if (rem > 0) begin
        rem--;
      end
    end
    @(negedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (started) begin
      chk("init_done", 64'(init_done), 64'(rem == 0));
      chk("resp_valid", 64'(rrv), 64'(exp_rv));
      if (rrv) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got %h expected no response", rrd);
        end else begin
          mon_e = q.pop_front();
          chk("resp_payload", rrd, mon_e);
          last_pl = mon_e;
        end
      end else begin
        chk("payload_hold", rrd, last_pl);
      end
    end
  end

  initial begin
    int n;
    nRST = 1'b0; arch_asid = '0; rqv = 1'b0; rqi = '0; uv = 1'b0; upc = '0;
    umdp = '0; flush = 1'b0;
    s_rst = 1'b0; s_asid = '0; s_rqv = 1'b0; s_rqi = '0; s_uv = 1'b0;
    s_upc = '0; s_umdp = '0; s_flush = 1'b0;
    clear_model();
    rem = SETS; exp_rv = 1'b0; last_pl = '0;
    #1 started = 1;
    @(negedge CLK); #1;
    step(); step();
    nRST = 1'b1;

    // Sweep after reset: a read returns zeros, an update is dropped.
    for (int c = 0; c < SETS; c++) begin
      rqv = (c == 10); rqi = 7'h05;
      uv = (c == 20); upc = pc(7'h22, 3); umdp = 8'h5A;
      step();
    end
    idle();
    rqv = 1'b1; rqi = 7'h22; step();
    idle(); step();

    // Fill every (index, lane) with random reads interleaved.
    for (int i = 0; i < SETS; i++) begin
      for (int l = 0; l < LANES; l++) begin
        uv = 1'b1; upc = pc(i, l); umdp = 8'(((l & 1) << 7) | i);
        rqv = ($urandom_range(0, 3) == 0); rqi = 7'($urandom);
        step();
      end
    end
    idle();

    // Readout through a nonzero ASID: index ~k hashes back to set k.
    arch_asid = 16'h007f;
    for (int k = 127; k >= 0; k--) begin
      rqv = 1'b1; rqi = ~7'(k); step();
    end
    idle(); step();

    // Same-cycle update and read of one set.
    arch_asid = '0;
    uv = 1'b1; upc = pc(16, 2); umdp = 8'h11; step();
    uv = 1'b1; upc = pc(16, 2); umdp = 8'hAB; rqv = 1'b1; rqi = 7'h10; step();
    idle(); step();

    // Randomised traffic with forced set collisions and rare flushes.
    for (int c = 0; c < 800; c++) begin
      arch_asid = 16'($urandom);
      rqv  = $urandom_range(0, 1) == 1;
      rqi  = 7'($urandom);
      uv   = $urandom_range(0, 1) == 1;
      upc  = pc($urandom_range(0, SETS - 1), $urandom_range(0, LANES - 1));
      if ($urandom_range(0, 3) == 0) upc[9:3] = rqi;
      umdp = 8'($urandom);
      flush = ($urandom_range(0, 299) == 0);
      step();
    end
    idle();
    for (int c = 0; c < 2 * SETS && rem != 0; c++) step();

    // Flush with a concurrent update and read.
    arch_asid = '0;
    flush = 1'b1; uv = 1'b1; upc = pc(7'h7f, 5); umdp = 8'hEE;
    rqv = 1'b1; rqi = 7'h7f; step();
    idle();
    repeat (SETS) step();
    rqv = 1'b1; rqi = 7'h7f; step();
    idle(); step();

    // Leave a nonzero payload, then reset in the middle of a sweep.
    uv = 1'b1; upc = pc(7'h33, 1); umdp = 8'h77; step();
    idle(); rqv = 1'b1; rqi = 7'h33; step();
    idle(); flush = 1'b1; step();
    idle(); repeat (60) step();
    nRST = 1'b0;
    #1;
    chk("async_rst_resp_valid", 64'(rrv), 64'd0);
    chk("async_rst_init_done", 64'(init_done), 64'd0);
    chk("async_rst_payload", rrd, 64'd0);
    clear_model(); rem = SETS; exp_rv = 1'b0; last_pl = '0; q.delete();
    step(); step();
    nRST = 1'b1;
    repeat (SETS) step();

    // Flush during a sweep restarts it.
    flush = 1'b1; step();
    idle(); repeat (100) step();
    flush = 1'b1; step();
    idle(); repeat (SETS) step();
    rqv = 1'b1; rqi = 7'h33; step();
    idle(); step();

    // Parameter variant.
    s_rst = 1'b1;
    n = 0;
    while (!s_init && n < 200) begin
      @(negedge CLK);
      n++;
    end
    #1;
    chk("small_sweep_len", 64'(n), 64'd32);
    s_uv = 1'b1; s_upc = {31'h1234567, 5'h1F, 2'd3}; s_umdp = 5'h15;
    @(negedge CLK); #1;
    s_uv = 1'b0; s_rqv = 1'b1; s_rqi = 5'h1F;
    @(negedge CLK); #1;
    s_rqv = 1'b0;
    chk("small_resp_valid", 64'(s_rrv), 64'd1);
    chk("small_payload", 64'(s_rrd), 64'h0A8000);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdpt_swept.md
Name: mdpt_swept

Overview:
- Parametrised successor to the memory dependence prediction table: one MDP_W-bit prediction per fetch lane per set, indexed by fetch index hashed with ASID.
- Sits beside the fetch pipeline: read request in stage N, per-lane predictions returned in N+1; single-lane training updates arrive from the LSQ/retire path.
- New vs. previous generation:
  - all widths/depths are parameters;
  - the table is cleared by a sweep state machine, so no reset is needed on the array and it maps to SRAM;
  - a flush input re-runs the sweep;
  - same-cycle update→read forwarding;
  - read response valid flag.

Parameters:
MDPT_SETS, 128, number of sets (power of 2, >=2); IDX_W = log2(MDPT_SETS)
FETCH_LANES, 8, predictions per set (power of 2, >=2); LANE_W = log2(FETCH_LANES)
MDP_W, 8, bits per prediction
ASID_W, 16, ASID width (>= IDX_W)
PC_W, 38, update PC width (>= IDX_W+LANE_W)

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
arch_asid  input  ASID_W  current address-space id
read_req_valid  input  1  read request this cycle
read_req_fetch_index  input  IDX_W  fetch set index
read_resp_valid  output  1  response valid (cycle after accepted request)
read_resp_mdp_by_lane  output  FETCH_LANES*MDP_W  lane i at bits [i*MDP_W +: MDP_W]
update_valid  input  1  training write
update_pc38  input  PC_W  PC of trained instruction
update_mdp  input  MDP_W  new prediction
flush_valid  input  1  clear whole table (restart sweep)
init_done  output  1  table cleared and usable

Behaviour:
- Hash: set = index ^ arch_asid[IDX_W-1:0].
  - Read index = read_req_fetch_index.
  - Update index = update_pc38[LANE_W +: IDX_W]; update lane = update_pc38[LANE_W-1:0]. Upper PC bits are ignored.
- Reset (async, nRST=0): read_resp_valid=0, read_resp_mdp_by_lane=0, init_done=0, sweep pointer=0, FSM=SWEEP. The array itself has no reset.
- FSM SWEEP:
  - Each cycle, write all lanes of set[ptr] to 0 and increment ptr.
  - At ptr==MDPT_SETS-1, go to READY the next cycle and set init_done=1.
  - Duration is exactly MDPT_SETS cycles after nRST rises.
- FSM READY: normal operation. flush_valid=1 → SWEEP with ptr=0 and init_done=0 from the next cycle.
- flush_valid during SWEEP restarts ptr at 0.
- While in SWEEP:
  - update_valid is dropped.
  - Read requests are still accepted: read_resp_valid=1 next cycle with an all-zero payload.
- Read path, READY:
  - read_req_valid at cycle N → read_resp_valid=1 and the set contents at N+1.
  - read_req_valid=0 → read_resp_valid=0 next cycle; the payload holds its last value (not cleared).
- Update, READY: writes only the addressed lane; other lanes are unchanged. Effective at edge N; visible to reads issued at N+1 or later.
- Forwarding: update and read to the same hashed set in the same cycle → the response shows update_mdp in the updated lane and stored values elsewhere (write-first).
- flush_valid and update_valid in the same cycle: the flush wins and the update is dropped.
- A flush in READY concurrent with a read: that read still returns pre-flush contents; reads issued from the next cycle onward return 0.
- arch_asid is sampled in the request/update cycle only.

Test Plan:
- Reset/sweep: nRST low 2 cycles, release → init_done=0 for 128 cycles, then 1. A read of index 0x05 during the sweep → resp_valid=1 with payload 0. Update to lane 3 during the sweep is dropped (a later read shows 0).
- Fill/readout: after init_done, asid=0, write every (index, lane) with mdp={lane[0], index[6:0]}.
  - Then asid=0x007f: read ~k for k=0x7f..0 → resp next cycle lanes 7..0 = {1,k},{0,k},…,{0,k}.
  - A final idle cycle → resp_valid=0, payload held at the k=0 pattern.
- Forwarding: set 0x10 lane 2 holds 0x11; same-cycle update pc38={…,0x10,3'h2} mdp 0xAB and read 0x10 → lane 2=0xAB, other lanes unchanged.
- Flush: table filled, flush_valid pulse with a concurrent update → init_done low for 128 cycles; afterwards read 0x7f → all lanes 0; the concurrent update is absent.
- Mid-sweep reset and flush: nRST asserted at ptr=60 → outputs zero immediately; after release the sweep takes a full 128 cycles. A flush at ptr=100 → init_done rises 128 cycles after the flush.
- Param variant MDPT_SETS=32, FETCH_LANES=4, MDP_W=5: sweep is 32 cycles; write lane 3 set 0x1F with 0x15, read 0x1F → bits [19:15]=0x15, others 0.
